axi_rd_arbiter: RTL
===================

Name: axi_rd_arbiter

Overview:
Shares one AXI4 read master port (AR + R channels) among NUM_SRC upstream read requesters. AR requests are granted round-robin, registered and held stable until accepted downstream. The source index is prefixed into ARID. R beats are routed back by decoding RID. Per-source outstanding-burst counters throttle each requester. The block sits between the requester fabric and the read port carried on axi_if.

Parameters:
NUM_SRC, 2, number of upstream requesters (2..8)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 64, read data width
ID_WIDTH, 32, downstream ID width; upstream ID width S_ID_WIDTH = ID_WIDTH - IDX_W
MAX_OUTSTANDING, 8, max un-completed bursts per source (>=1)
IDX_W (localparam), $clog2(NUM_SRC), source-index field width
CNT_W (localparam), $clog2(MAX_OUTSTANDING+1), counter width

Ports:
sig_clock  in  1  clock
sig_reset  in  1  asynchronous, active-high reset
s_arvalid  in  NUM_SRC  per-source AR valid
s_arready  out  NUM_SRC  per-source AR ready
s_arid  in  NUM_SRC*S_ID_WIDTH  per-source ARID
s_araddr  in  NUM_SRC*ADDR_WIDTH  per-source ARADDR
s_arlen/s_arsize/s_arburst  in  NUM_SRC*8 / *3 / *2  per-source burst attributes
s_rvalid  out  NUM_SRC  per-source R valid
s_rready  in  NUM_SRC  per-source R ready
s_rid  out  S_ID_WIDTH  shared RID, low bits of m_rid
s_rdata/s_rresp/s_rlast  out  DATA_WIDTH / 2 / 1  shared R payload
m_arvalid/m_arready  out/in  1/1  downstream AR handshake
m_arid/m_araddr/m_arlen/m_arsize/m_arburst  out  ID_WIDTH/ADDR_WIDTH/8/3/2  downstream AR payload
m_rvalid/m_rready  in/out  1/1  downstream R handshake
m_rid/m_rdata/m_rresp/m_rlast  in  ID_WIDTH/DATA_WIDTH/2/1  downstream R payload
outstanding  out  NUM_SRC*CNT_W  per-source outstanding counters
err_protocol  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, sig_reset=1): state=IDLE, m_arvalid=0, s_arready=0, all AR payload registers=0, counters=0, rr_ptr=0, err_protocol=0. Holds until sig_reset deasserts.
- Eligible source i: s_arvalid[i]=1 and outstanding[i] < MAX_OUTSTANDING.
- AR state machine, states IDLE and SEND:
  - IDLE: if any source is eligible, pick the first eligible index at or after rr_ptr, with wraparound. In the same cycle, s_arready[winner]=1, combinationally. Only the winner's ready is ever high.
  - On that clock edge: capture m_arid={winner, s_arid[winner]} and the addr/len/size/burst fields, store the winner index, and go to SEND.
  - SEND: m_arvalid=1; payload comes from registers and stays stable while m_arready=0. All s_arready=0.
  - On m_arready=1: go to IDLE, outstanding[winner]+=1, rr_ptr=(winner+1) mod NUM_SRC.
- AR timing: an accepted request drives m_arvalid one cycle after the s_ handshake. Peak throughput is one AR every 2 cycles. An ineligible source is skipped, never stalled on.
- R path, combinational, no storage:
  - idx = m_rid[ID_WIDTH-1 -: IDX_W].
  - s_rvalid[idx]=m_rvalid; all other s_rvalid=0.
  - m_rready=s_rready[idx].
  - s_rid/s_rdata/s_rresp/s_rlast are broadcast from the m_ side.
- Bad RID: if m_rvalid=1 and idx >= NUM_SRC, then m_rready=1 (beat dropped), no s_rvalid is asserted, and err_protocol is set.
- Counter completion: a beat with m_rvalid & m_rready & m_rlast decrements outstanding[idx].
- Simultaneous increment and decrement of the same counter leaves it unchanged.
- Decrement at 0 saturates at 0 and sets err_protocol.
- err_protocol clears only on reset.
- Width rule: s_rid = m_rid[S_ID_WIDTH-1:0]. The counter never exceeds MAX_OUTSTANDING.

Decomposition:
- axi_arb_pkg holds:
  - burst-type enum (FIXED/INCR/WRAP);
  - RRESP constants (OKAY/EXOKAY/SLVERR/DECERR);
  - ar_payload_t struct {id, addr, len, size, burst};
  - AR state enum {IDLE, SEND}.
- Sub-module rr_arbiter: combinational round-robin pick from a request vector and pointer, producing a one-hot grant plus an index.

Test Plan:
1. Reset: assert sig_reset mid-SEND with m_arvalid=1 -> m_arvalid=0, all counters 0 and state IDLE immediately; after release the first grant goes to source 0.
2. Round-robin: sources 0 and 1 both request continuously, m_arready=1 -> m_arid upper bit alternates 0,1,0,1; each AR appears one cycle after its s_arready pulse.
3. Stability: m_arready held 0 for 5 cycles with araddr=0x1000_0040, arlen=7 -> m_araddr and m_arlen unchanged all 5 cycles; no second s_arready during that time.
4. Throttle: MAX_OUTSTANDING=2, source 0 issues 3 ARs with no R returned -> third not granted and outstanding[0]=2; after one RLAST beat with rid upper bit 0 -> third granted.
5. R routing: m_rid={1,0x5}, 4 beats, s_rready[1] low for 2 cycles -> only s_rvalid[1] high, m_rready tracks s_rready[1], s_rid=0x5, outstanding[1] decrements on beat 4 only.
6. Errors: NUM_SRC=3, m_rid upper bits=3 -> beat consumed with m_rready=1, no s_rvalid, err_protocol=1; RLAST on an idle source -> counter stays 0 and err_protocol stays set.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared types for the AXI read arbiter.
// The payload struct is sized for the default ID/address widths of the arbiter.
package axi_arb_pkg;
    localparam int ID_W = 32;
    localparam int ADDR_W = 32;
    typedef enum logic [1:0] {BURST_FIXED = 2'd0, BURST_INCR = 2'd1, BURST_WRAP = 2'd2} burst_t;
    typedef enum logic [1:0] {RESP_OKAY = 2'd0, RESP_EXOKAY = 2'd1, RESP_SLVERR = 2'd2, RESP_DECERR = 2'd3} resp_t;
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        burst_t            burst;
    } ar_payload_t;
    typedef enum logic {IDLE, SEND} ar_state_t;
endpackage

// File: rtl/axi_if.sv
// axi_if: one AXI4 read port (AR + R channels).
interface axi_if #(
    parameter int ID_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  rvalid;
    logic                  rready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );
    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at or after ptr.
module rr_arbiter #(
    parameter int N = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;
    // rotate so the pointer position lands on bit 0, then take the lowest set bit
    assign rot = N'({req, req} >> ptr);
    always_comb begin
        off = '0;
        for (int k = N - 1; k >= 0; k--)
            if (rot[k]) off = IDX_W'(k);
    end
    assign sum   = {1'b0, ptr} + {1'b0, off};
    assign idx   = IDX_W'(int'(sum) >= N ? int'(sum) - N : int'(sum));
    assign any   = |req;
    assign grant = any ? N'(1) << idx : '0;
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI4 read port among NUM_SRC requesters.
// Round-robin AR grant with registered payload, RID-indexed R routing, per-source throttle.
module axi_rd_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH = 32,
    parameter int MAX_OUTSTANDING = 8,
    localparam int IDX_W = $clog2(NUM_SRC),
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1),
    localparam int S_ID_WIDTH = ID_WIDTH - IDX_W
) (
    input  logic                          sig_clock,
    input  logic                          sig_reset,
    input  logic [NUM_SRC-1:0]            s_arvalid,
    output logic [NUM_SRC-1:0]            s_arready,
    input  logic [NUM_SRC*S_ID_WIDTH-1:0] s_arid,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0] s_araddr,
    input  logic [NUM_SRC*8-1:0]          s_arlen,
    input  logic [NUM_SRC*3-1:0]          s_arsize,
    input  logic [NUM_SRC*2-1:0]          s_arburst,
    output logic [NUM_SRC-1:0]            s_rvalid,
    input  logic [NUM_SRC-1:0]            s_rready,
    output logic [S_ID_WIDTH-1:0]         s_rid,
    output logic [DATA_WIDTH-1:0]         s_rdata,
    output logic [1:0]                    s_rresp,
    output logic                          s_rlast,
    axi_if.master                         m,
    output logic [NUM_SRC*CNT_W-1:0]      outstanding,
    output logic                          err_protocol
);
    ar_state_t                      state, state_d;
    ar_payload_t                    ar_q, ar_d;
    logic [IDX_W-1:0]               rr_ptr, win_q, win, r_idx;
    logic [NUM_SRC-1:0]             eligible, grant, inc, dec;
    logic [NUM_SRC-1:0][CNT_W-1:0]  cnt;
    logic                           any, accept, bad, beat_done;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_SRC; i++)
            eligible[i] = s_arvalid[i] && (int'(cnt[i]) < MAX_OUTSTANDING);
    end

    rr_arbiter #(.N(NUM_SRC), .IDX_W(IDX_W)) u_rr (
        .req(eligible), .ptr(rr_ptr), .grant(grant), .idx(win), .any(any)
    );

    always_comb begin
        state_d   = state;
        s_arready = '0;
        m.arvalid = 1'b0;
        if (state == IDLE) begin
            s_arready = sig_reset ? '0 : grant;
            state_d   = any ? SEND : IDLE;
        end else begin
            m.arvalid = 1'b1;
            state_d   = m.arready ? IDLE : SEND;
        end
    end

    assign accept = (state == SEND) && m.arready;
    assign ar_d = '{
        id:    ID_W'({win, s_arid[int'(win)*S_ID_WIDTH +: S_ID_WIDTH]}),
        addr:  ADDR_W'(s_araddr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH]),
        len:   s_arlen[int'(win)*8 +: 8],
        size:  s_arsize[int'(win)*3 +: 3],
        burst: burst_t'(s_arburst[int'(win)*2 +: 2])
    };

    always_ff @(posedge sig_clock or posedge sig_reset) begin
        if (sig_reset) begin
            state  <= IDLE;
            ar_q   <= '0;
            win_q  <= '0;
            rr_ptr <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && any) begin
                ar_q  <= ar_d;
                win_q <= win;
            end
            if (accept) rr_ptr <= (int'(win_q) == NUM_SRC - 1) ? '0 : win_q + IDX_W'(1);
        end
    end

    assign m.arid    = ar_q.id[ID_WIDTH-1:0];
    assign m.araddr  = ar_q.addr[ADDR_WIDTH-1:0];
    assign m.arlen   = ar_q.len;
    assign m.arsize  = ar_q.size;
    assign m.arburst = ar_q.burst;

    // an RID naming a nonexistent source is swallowed so the port cannot deadlock
    assign r_idx     = m.rid[ID_WIDTH-1 -: IDX_W];
    assign bad       = int'(r_idx) >= NUM_SRC;
    assign m.rready  = bad | s_rready[r_idx];
    assign s_rvalid  = (m.rvalid && !bad) ? NUM_SRC'(1) << r_idx : '0;
    assign s_rid     = m.rid[S_ID_WIDTH-1:0];
    assign s_rdata   = m.rdata;
    assign s_rresp   = m.rresp;
    assign s_rlast   = m.rlast;
    assign beat_done = m.rvalid && m.rready && m.rlast && !bad;

    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            inc[i] = accept && (int'(win_q) == i);
            dec[i] = beat_done && (int'(r_idx) == i);
        end
    end

    always_ff @(posedge sig_clock or posedge sig_reset) begin
        if (sig_reset) begin
            cnt          <= '0;
            err_protocol <= 1'b0;
        end else begin
            if (m.rvalid && bad) err_protocol <= 1'b1;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (inc[i] && !dec[i]) cnt[i] <= cnt[i] + CNT_W'(1);
                else if (dec[i] && !inc[i]) begin
                    if (cnt[i] == '0) err_protocol <= 1'b1;
                    else cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    assign outstanding = cnt;
endmodule
